// File: rtl/kronos_counter64_pkg.sv
// Shared types and constants for the 64-bit CSR event counter.
package kronos_types;

  localparam int unsigned            CNT_W       = 32;
  localparam logic [CNT_W-1:0]       CNT_LOW_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    CNT_IDLE,
    CNT_RESP
  } cnt_state_e;

endpackage

// File: rtl/kronos_counter64_if.sv
// CSR-side request/acknowledge bus between the CSR unit and a counter.
interface kronos_counter64_if;
  import kronos_types::*;

  logic             req;
  logic             we;
  logic             hi;
  logic [CNT_W-1:0] wdata;
  logic             ack;
  logic [CNT_W-1:0] rdata;

  modport master (
    output req, we, hi, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, hi, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/kronos_counter64.sv
// 64-bit event counter (mcycle/minstret storage) with a CSR responder port.
// The increment is split into two 32-bit halves joined by a registered carry;
// high-word reads add the pending carry so they never observe a stale value.
module kronos_counter64
  import kronos_types::*;
#(
  parameter bit HIGH_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                incr,
  input  logic                inhibit,
  kronos_counter64_if.slave   bus,
  output logic                ovf
);

  cnt_state_e       state_q;
  cnt_state_e       state_d;

  logic [CNT_W-1:0] count_low;
  logic [CNT_W-1:0] count_high;
  logic             carry;
  logic [CNT_W-1:0] rdata_q;

  logic             accept;
  logic             inc;
  logic             wr_lo;
  logic             wr_hi;
  logic             low_wrap;
  logic             carry_apply;
  logic [CNT_W-1:0] rd_value;

  // State register for the request/response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CNT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, always return from RESP (req ignored there).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CNT_IDLE: if (bus.req) state_d = CNT_RESP;
      CNT_RESP: state_d = CNT_IDLE;
      default:  state_d = CNT_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    accept    = (state_q == CNT_IDLE) && bus.req;
    bus.ack   = (state_q == CNT_RESP);
    bus.rdata = rdata_q;
  end

  // Datapath controls: write priority, wrap detection and read fix-up.
  always_comb begin
    inc         = incr & ~inhibit;
    wr_lo       = accept & bus.we & ~bus.hi;
    wr_hi       = accept & bus.we & bus.hi & HIGH_EN;
    // A low write suppresses both the increment and the carry it would create.
    low_wrap    = inc & ~wr_lo & (count_low == CNT_LOW_MAX);
    // A high write drops any carry pending in the same cycle.
    carry_apply = carry & ~wr_hi;
    if (!bus.hi) begin
      rd_value = count_low;
    end else if (HIGH_EN) begin
      rd_value = count_high + {{(CNT_W-1){1'b0}}, carry};
    end else begin
      rd_value = '0;
    end
  end

  // Counter halves, pending carry and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_low  <= '0;
      count_high <= '0;
      carry      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (wr_lo) begin
        count_low <= bus.wdata;
      end else if (inc) begin
        count_low <= count_low + CNT_W'(1);
      end

      if (HIGH_EN) begin
        if (wr_hi) begin
          count_high <= bus.wdata;
        end else if (carry) begin
          count_high <= count_high + CNT_W'(1);
        end
        // Carry lives exactly one cycle: it is either applied or dropped,
        // while a same-cycle low wrap re-arms it on top of a written high word.
        carry <= low_wrap;
        ovf   <= carry_apply & (count_high == CNT_LOW_MAX);
      end else begin
        count_high <= '0;
        carry      <= 1'b0;
        ovf        <= low_wrap;
      end
    end
  end

  // Read data captured on the accepting edge, held until the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= rd_value;
    end
  end

endmodule

// File: tb/tb_kronos_counter64.sv
// Directed bench for kronos_counter64: handshake, carry fix-up, wrap, inhibit.
module tb_kronos_counter64;

  logic clk;
  logic rst;
  logic incr;
  logic inhibit;
  logic ovf;

  int unsigned errors;
  int unsigned checks;

  kronos_counter64_if bus ();

  kronos_counter64 #(.HIGH_EN(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .incr    (incr),
    .inhibit (inhibit),
    .bus     (bus),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete access; entered and left on a negedge with the FSM idle.
  task automatic access(input logic w, input logic h, input logic [31:0] d,
                        output logic got_ack, output logic [31:0] got);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.hi    = h;
    bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
    got_ack   = bus.ack;
    got       = bus.rdata;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic a;
    logic [31:0] r;
    rst = 1'b1; incr = 1'b0; inhibit = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.hi = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0 || bus.rdata !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rdata=%h ovf=%b, want 0/0/0", bus.ack, bus.rdata, ovf);
    end
    access(1'b0, 1'b0, '0, a, r);
    checks++;
    if (a !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL reset_low: ack=%b rdata=%h, want 1/00000000", a, r);
    end
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (a !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL reset_high: ack=%b rdata=%h, want 1/00000000", a, r);
    end
  endtask

  task automatic test_reset_mid_access();
    logic a;
    logic [31:0] r;
    access(1'b1, 1'b1, 32'h0000_ABCD, a, r);
    access(1'b1, 1'b0, 32'h0000_5555, a, r);
    bus.req = 1'b1; bus.we = 1'b1; bus.hi = 1'b0; bus.wdata = 32'h0000_1234;
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ack_in_reset: ack=%b, want 0", bus.ack);
    end
    rst = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0 || bus.rdata !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: ack=%b rdata=%h ovf=%b, want 0/0/0", bus.ack, bus.rdata, ovf);
    end
    access(1'b0, 1'b0, '0, a, r);
    checks++;
    if (a !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL midrst_low: ack=%b rdata=%h, want 1/00000000", a, r);
    end
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (a !== 1'b1 || r !== 32'h0) begin
      errors++;
      $display("FAIL midrst_high: ack=%b rdata=%h, want 1/00000000", a, r);
    end
  endtask

  task automatic test_staggered_carry();
    logic a;
    logic [31:0] r;
    access(1'b1, 1'b0, 32'hFFFF_FFFF, a, r);
    access(1'b1, 1'b1, 32'h1234_5677, a, r);
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (r !== 32'h1234_5677) begin
      errors++;
      $display("FAIL carry_prewrap_high: rdata=%h, want 12345677", r);
    end
    incr = 1'b1;
    @(negedge clk);
    // low wrapped on the last edge; carry is pending in this cycle
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (a !== 1'b1 || r !== 32'h1234_5678) begin
      errors++;
      $display("FAIL carry_pending_high: ack=%b rdata=%h, want 1/12345678", a, r);
    end
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (r !== 32'h1234_5678) begin
      errors++;
      $display("FAIL carry_applied_high: rdata=%h, want 12345678", r);
    end
    incr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_collision();
    logic a;
    logic [31:0] r;
    incr = 1'b1;
    access(1'b1, 1'b0, 32'h0000_00A0, a, r);
    access(1'b0, 1'b0, '0, a, r);
    checks++;
    if (r !== 32'h0000_00A1) begin
      errors++;
      $display("FAIL collision_first_read: rdata=%h, want 000000a1", r);
    end
    access(1'b0, 1'b0, '0, a, r);
    checks++;
    if (r !== 32'h0000_00A3) begin
      errors++;
      $display("FAIL collision_second_read: rdata=%h, want 000000a3", r);
    end
    incr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap64();
    logic a;
    logic [31:0] r;
    int unsigned pulses;
    access(1'b1, 1'b1, 32'hFFFF_FFFF, a, r);
    access(1'b1, 1'b0, 32'hFFFF_FFFF, a, r);
    incr = 1'b1;
    @(negedge clk);
    incr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf_early: ovf=%b, want 0", ovf);
    end
    @(negedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ovf_pulse: ovf=%b, want 1", ovf);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ovf === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL wrap_ovf_width: extra pulses=%0d, want 0", pulses);
    end
    access(1'b0, 1'b0, '0, a, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL wrap_low: rdata=%h, want 00000000", r);
    end
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL wrap_high: rdata=%h, want 00000000", r);
    end
  endtask

  task automatic test_inhibit();
    logic a;
    logic [31:0] r;
    access(1'b1, 1'b1, 32'h0000_0010, a, r);
    access(1'b1, 1'b0, 32'hFFFF_FFFF, a, r);
    incr = 1'b1;
    @(negedge clk);
    inhibit = 1'b1;
    repeat (50) @(negedge clk);
    access(1'b0, 1'b0, '0, a, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL inhibit_low: rdata=%h, want 00000000", r);
    end
    access(1'b0, 1'b1, '0, a, r);
    checks++;
    if (r !== 32'h0000_0011) begin
      errors++;
      $display("FAIL inhibit_high: rdata=%h, want 00000011", r);
    end
    incr = 1'b0;
    inhibit = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [31:0] r;
    logic prev_ack;
    int unsigned acks;
    int unsigned consec;
    access(1'b1, 1'b0, 32'h0000_0100, a, r);
    incr = 1'b1;
    bus.req = 1'b1; bus.we = 1'b0; bus.hi = 1'b0;
    acks = 0; consec = 0; prev_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.ack !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_ack_cycle%0d: ack=%b, want %b", i, bus.ack, ((i % 2) == 0));
      end
      if (bus.ack === 1'b1) begin
        acks++;
        if (prev_ack) consec++;
        checks++;
        if (bus.rdata !== 32'h0000_0100 + 32'(i)) begin
          errors++;
          $display("FAIL b2b_rdata_cycle%0d: rdata=%h, want %h", i, bus.rdata, 32'h0000_0100 + 32'(i));
        end
      end
      prev_ack = bus.ack;
    end
    bus.req = 1'b0;
    incr = 1'b0;
    checks++;
    if (acks != 10 || consec != 0) begin
      errors++;
      $display("FAIL b2b_count: acks=%0d consecutive=%0d, want 10/0", acks, consec);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_reset_mid_access();
    test_staggered_carry();
    test_write_collision();
    test_wrap64();
    test_inhibit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kronos_counter64.md
# kronos_counter64

64-bit event counter with a CSR-side request/acknowledge responder port. It is the storage and response end of the CSR counter path used for mcycle/minstret: the CSR unit issues read/write requests, and the block returns the old value. The 64-bit increment is split into two 32-bit halves with a registered carry, which keeps the adder off the critical path. A fix-up on the read path guarantees that a high-word read never misses a pending carry.

## Interface
- `HIGH_EN`, default 1: implement the upper 32 bits. When 0, the high word reads 0, high writes are ignored, no carry is generated, and `ovf` pulses on low-word wrap.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `incr` in 1: count event, +1 per cycle when high.
- `inhibit` in 1: when high, `incr` is ignored (mcountinhibit bit).
- `req` in 1: CSR access request.
- `we` in 1: write enable, qualified by `req`.
- `hi` in 1: word select. 0 = bits [31:0], 1 = bits [63:32].
- `wdata` in 32: write data, qualified by `req & we`.
- `ack` out 1: one-cycle acknowledge pulse.
- `rdata` out 32: old value of the selected word, valid while `ack` is high.
- `ovf` out 1: one-cycle pulse on 64-bit wrap.

## Operation
- State: `count_low[31:0]`, `count_high[31:0]`, `carry` (pending carry into high), FSM {IDLE, RESP}.
- Counting (per cycle, `inc = incr & ~inhibit`):
  - Low word: if `inc`, `count_low <= count_low + 1`.
  - Wrap: if `inc` and `count_low == 32'hFFFF_FFFF`, then `count_low <= 0` and `carry <= 1`.
  - Carry apply: if `carry`, then `count_high <= count_high + 1` and `carry <= 0` in the next cycle. `inhibit` does not block a pending carry.
  - Overflow: if `carry` is applied while `count_high == 32'hFFFF_FFFF`, the high word wraps to 0 and `ovf` pulses in the following cycle.
- Read value, sampled in the IDLE cycle that accepts `req`:
  - `hi=0`: `count_low`.
  - `hi=1`: `count_high + carry`, 32-bit modulo.
  - This is registered into `rdata`.
- Write, applied on the accepting edge:
  - `hi=0`: `count_low <= wdata`. Write wins over a same-cycle `inc`, and no carry is generated that cycle.
  - `hi=1`: `count_high <= wdata` and `carry <= 0`. Write wins over a same-cycle carry apply, and the carry is dropped.
  - A same-cycle low wrap still sets `carry`, which then applies to the written high value.
- FSM transitions:
  - IDLE & `req`: go to RESP. The access is performed and `rdata` is captured.
  - RESP: `ack=1`, go to IDLE unconditionally. `req` is ignored in RESP.
  - A held `req` therefore yields one access every 2 cycles.

## Timing
- Reset values: `count_low=0`, `count_high=0`, `carry=0`, FSM=IDLE, `ack=0`, `rdata=0`, `ovf=0`.
- Reset mid-access aborts it with no `ack`. A write accepted on the edge coincident with reset assertion is lost.
- Latency: `req` accepted in cycle N, then `ack`/`rdata` in N+1. A write is visible to a request accepted in N+1 or later.
- The requester holds `req`, `we`, `hi`, and `wdata` stable until `ack`, then drops or changes them in the cycle after `ack`.
- Carry visibility:
  - Low wraps on edge E, so the high word is updated on E+1.
  - A high read accepted in the cycle between E and E+1 still returns the incremented value through the fix-up.
- Counting continues every cycle regardless of FSM state.
- `ovf` is registered, one cycle wide, and asserts 2 edges after the wrapping low increment.

## Structure
- In `kronos_types`:
  - Localparams `CNT_W=32` and `CNT_LOW_MAX=32'hFFFF_FFFF`.
  - Enum `cnt_state_e {CNT_IDLE, CNT_RESP}`.
- Single module; no sub-module is warranted. The two halves differ in carry/fix-up handling, so a shared half-counter would only obscure it.
- The CSR unit instantiates two copies (cycle: `incr=1`; instret: `incr`=retire) and maps MCYCLE/MCYCLEH/MINSTRET/MINSTRETH to `hi`.

## Test plan
- Reset mid-access:
  - Stimulus: `req=1` (write) accepted, then `rst` pulsed before `ack`.
  - Response: `ack` never asserts; `count_low=0`, `count_high=0`, `rdata=0`, `ovf=0`; the next `req` is acked 1 cycle after acceptance.
- Staggered carry read:
  - Stimulus: write low=`FFFF_FFFF`, write high=`1234_5677`, `incr=1` continuously; issue high reads.
  - Response: every high read after the wrap returns `1234_5678`, including one accepted in the carry-pending cycle.
- Write/increment collision:
  - Stimulus: `incr=1` with low write `0000_00A0`, then low read.
  - Response: read returns `0000_00A0` + (cycles elapsed after the write edge); exactly `0000_00A1` when the read is accepted on the cycle after `ack` of the write.
- 64-bit wrap:
  - Stimulus: high=`FFFF_FFFF`, low=`FFFF_FFFF`, one `incr` pulse.
  - Response: `ovf` pulses once, 2 cycles later; both words read 0.
- Inhibit:
  - Stimulus: `inhibit=1`, `incr=1` for 50 cycles, with a carry pending at inhibit assertion.
  - Response: low unchanged; high still increments by exactly 1.
- Handshake throughput:
  - Stimulus: `req` held high with `we=0` for 20 cycles.
  - Response: exactly 10 `ack` pulses, never on consecutive cycles; each `rdata` equals the value at its accepting cycle.
